// File: rtl/alut_mem_arb13_pkg.sv
// Shared constants and types for the ALUT memory arbiter: memory geometry,
// owner encoding and the default starvation / lock-timeout limits.
package alut_pkg13;

  localparam int ALUT_AW = 8;
  localparam int ALUT_DW = 83;

  localparam logic [7:0] STARVE_LIM_DEF = 8'd16;
  localparam logic [8:0] LOCK_MAX_DEF   = 9'd300;

  // Owner encoding doubles as the FSM state and the arb_owner output; OWN_NONE is IDLE.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_ADD  = 2'd1,
    OWN_AGE  = 2'd2,
    OWN_APB  = 2'd3
  } owner_e;

endpackage

// File: rtl/alut_mem_arb13_if.sv
// Requester and memory-macro signals of the ALUT arbiter. The arbiter takes the
// slave view; requesters plus the memory macro take the master view.
interface alut_mem_arb13_if;

  logic                          req_add, req_age, req_apb;
  logic                          lock_add, lock_age, lock_apb;
  logic [alut_pkg13::ALUT_AW-1:0] addr_add, addr_age, addr_apb;
  logic                          we_add, we_age, we_apb;
  logic [alut_pkg13::ALUT_DW-1:0] wdata_add, wdata_age, wdata_apb;
  logic                          gnt_add, gnt_age, gnt_apb;
  logic                          rd_vld_add, rd_vld_age, rd_vld_apb;
  logic                          mem_cs, mem_we;
  logic [alut_pkg13::ALUT_AW-1:0] mem_addr;
  logic [alut_pkg13::ALUT_DW-1:0] mem_wdata, mem_rdata, rdata;
  logic [1:0]                    arb_owner;

  modport slave (
    input  req_add, req_age, req_apb, lock_add, lock_age, lock_apb,
           addr_add, addr_age, addr_apb, we_add, we_age, we_apb,
           wdata_add, wdata_age, wdata_apb, mem_rdata,
    output gnt_add, gnt_age, gnt_apb, rd_vld_add, rd_vld_age, rd_vld_apb,
           mem_cs, mem_we, mem_addr, mem_wdata, rdata, arb_owner
  );

  modport master (
    output req_add, req_age, req_apb, lock_add, lock_age, lock_apb,
           addr_add, addr_age, addr_apb, we_add, we_age, we_apb,
           wdata_add, wdata_age, wdata_apb, mem_rdata,
    input  gnt_add, gnt_age, gnt_apb, rd_vld_add, rd_vld_age, rd_vld_apb,
           mem_cs, mem_we, mem_addr, mem_wdata, rdata, arb_owner
  );

endinterface

// File: rtl/alut_mem_arb13_wait_cnt.sv
// Saturating wait counter for one requester; promote_o stays high once the
// requester has waited LIM cycles, until it is finally granted.
module alut_wait_cnt13 #(
  parameter logic [7:0] LIM = alut_pkg13::STARVE_LIM_DEF
) (
  input  logic pclk13,
  input  logic n_p_reset13,
  input  logic req_i,
  input  logic gnt_i,
  output logic promote_o
);

  logic [7:0] cnt_q, cnt_d;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (gnt_i)
      cnt_d = '0;
    else if (req_i && (cnt_q != LIM))
      cnt_d = cnt_q + 8'd1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge pclk13 or negedge n_p_reset13) begin
    if (!n_p_reset13)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign promote_o = (cnt_q == LIM);

endmodule

// File: rtl/alut_mem_arb13.sv
// Fixed-priority arbiter and sequencer for the single-port 256x83 ALUT memory,
// with owner locking, lock timeout and starvation promotion for AGE/APB.
module alut_mem_arb13 #(
  parameter logic [7:0] STARVE_LIM = alut_pkg13::STARVE_LIM_DEF,
  parameter logic [8:0] LOCK_MAX   = alut_pkg13::LOCK_MAX_DEF
) (
  input logic             pclk13,
  input logic             n_p_reset13,
  alut_mem_arb13_if.slave bus
);
  import alut_pkg13::*;

  owner_e     state_q, state_d;
  owner_e     winner;
  logic [8:0] lock_cnt_q, lock_cnt_d;
  logic       gnt_add, gnt_age, gnt_apb;
  logic       promote_age, promote_apb;
  logic       owner_lock, others_pend, lock_hold;
  logic       rd_vld_add_q, rd_vld_age_q, rd_vld_apb_q;

  assign gnt_add = (state_q == OWN_ADD) && bus.req_add;
  assign gnt_age = (state_q == OWN_AGE) && bus.req_age;
  assign gnt_apb = (state_q == OWN_APB) && bus.req_apb;

  assign bus.gnt_add = gnt_add;
  assign bus.gnt_age = gnt_age;
  assign bus.gnt_apb = gnt_apb;
  assign bus.mem_cs  = gnt_add | gnt_age | gnt_apb;

  // Grants are one-hot, so the AND-OR mux drives all-zero strobes when idle.
  assign bus.mem_we    = (gnt_add & bus.we_add) | (gnt_age & bus.we_age) | (gnt_apb & bus.we_apb);
  assign bus.mem_addr  = ({ALUT_AW{gnt_add}} & bus.addr_add)
                       | ({ALUT_AW{gnt_age}} & bus.addr_age)
                       | ({ALUT_AW{gnt_apb}} & bus.addr_apb);
  assign bus.mem_wdata = ({ALUT_DW{gnt_add}} & bus.wdata_add)
                       | ({ALUT_DW{gnt_age}} & bus.wdata_age)
                       | ({ALUT_DW{gnt_apb}} & bus.wdata_apb);

  assign bus.rdata     = bus.mem_rdata;
  assign bus.arb_owner = state_q;

  alut_wait_cnt13 #(.LIM(STARVE_LIM)) u_wait_age (
    .pclk13      (pclk13),
    .n_p_reset13 (n_p_reset13),
    .req_i       (bus.req_age),
    .gnt_i       (gnt_age),
    .promote_o   (promote_age)
  );

  alut_wait_cnt13 #(.LIM(STARVE_LIM)) u_wait_apb (
    .pclk13      (pclk13),
    .n_p_reset13 (n_p_reset13),
    .req_i       (bus.req_apb),
    .gnt_i       (gnt_apb),
    .promote_o   (promote_apb)
  );

  always_comb begin
    owner_lock  = 1'b0;
    others_pend = 1'b0;
    winner      = OWN_NONE;
    case (state_q)
      OWN_NONE: owner_lock = 1'b0;
      OWN_ADD: begin
        owner_lock  = bus.lock_add;
        others_pend = bus.req_age | bus.req_apb;
      end
      OWN_AGE: begin
        owner_lock  = bus.lock_age;
        others_pend = bus.req_add | bus.req_apb;
      end
      OWN_APB: begin
        owner_lock  = bus.lock_apb;
        others_pend = bus.req_add | bus.req_age;
      end
    endcase

    if (promote_age && bus.req_age)      winner = OWN_AGE;
    else if (promote_apb && bus.req_apb) winner = OWN_APB;
    else if (bus.req_add)                winner = OWN_ADD;
    else if (bus.req_age)                winner = OWN_AGE;
    else if (bus.req_apb)                winner = OWN_APB;

    // A lock is honoured unless it has run LOCK_MAX cycles while someone else waits.
    lock_hold = owner_lock && !((lock_cnt_q == LOCK_MAX) && others_pend);
    state_d   = lock_hold ? state_q : winner;

    lock_cnt_d = '0;
    if (owner_lock && (state_d == state_q))
      lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + 9'd1;
  end

  always_ff @(posedge pclk13 or negedge n_p_reset13) begin
    if (!n_p_reset13) begin
      state_q      <= OWN_NONE;
      lock_cnt_q   <= '0;
      rd_vld_add_q <= 1'b0;
      rd_vld_age_q <= 1'b0;
      rd_vld_apb_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_vld_add_q <= gnt_add & ~bus.mem_we;
      rd_vld_age_q <= gnt_age & ~bus.mem_we;
      rd_vld_apb_q <= gnt_apb & ~bus.mem_we;
    end
  end

  assign bus.rd_vld_add = rd_vld_add_q;
  assign bus.rd_vld_age = rd_vld_age_q;
  assign bus.rd_vld_apb = rd_vld_apb_q;

endmodule
